// File: rtl/nv_ram_rws_param.sv
// Parametrised one-read/one-write synchronous RAM: lane write mask, selectable
// read-during-write behaviour, optional output register and post-reset clear walk.
module nv_ram_rws_param #(
  parameter int  DEPTH        = 32,
  parameter int  DW           = 256,
  parameter int  MW           = 8,
  parameter int  DOUT_REG     = 0,
  parameter int  COLL_MODE    = 1,
  parameter int  CLEAR_ON_RST = 1,
  localparam int AW           = $clog2(DEPTH),
  localparam int NL           = DW / MW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [NL-1:0] wmask,
  input  logic [DW-1:0] di,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic          init_done
);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  localparam logic [AW:0]   DEPTH_W     = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);
  localparam bit            CLEAR_EN    = (CLEAR_ON_RST != 0);
  localparam bit            WRITE_FIRST = (COLL_MODE != 0);

  state_e          state_q;
  logic [AW-1:0]   clr_addr_q;
  logic            init_done_q;

  logic [DW-1:0]   mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [DW-1:0]   mem_wd;
  logic [NL-1:0]   mem_wm;

  logic            ra_ok;
  logic            wa_ok;
  logic            rd_fire;
  logic            clear_wr;
  logic [DW-1:0]   rd_data_d;
  logic [DW-1:0]   rd_data_q;
  logic            rd_vld_q;
  logic            unused_pwrbus;

  assign unused_pwrbus = ^pwrbus_ram_pd;
  assign ra_ok         = ({1'b0, ra} < DEPTH_W);
  assign wa_ok         = ({1'b0, wa} < DEPTH_W);
  assign rd_fire       = init_done_q & re;
  assign clear_wr      = CLEAR_EN && (state_q == ST_CLEAR);
  assign init_done     = init_done_q;

  // init_done trails the last clear write by one edge; accesses are gated on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (!CLEAR_EN || (clr_addr_q == LAST_ADDR)) begin
            state_q     <= ST_READY;
            init_done_q <= !CLEAR_EN;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        ST_READY: init_done_q <= 1'b1;
      endcase
    end
  end

  // Single write port shared by the clear walk and user writes.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wa;
    mem_wd = di;
    mem_wm = wmask;
    if (clear_wr) begin
      mem_we = 1'b1;
      mem_wa = clr_addr_q;
      mem_wd = '0;
      mem_wm = '1;
    end else if (init_done_q && we && wa_ok) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; zeroing is done by the clear walk.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < NL; l++) begin
        if (mem_wm[l]) mem[mem_wa][l*MW +: MW] <= mem_wd[l*MW +: MW];
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (ra_ok) begin
      rd_data_d = mem[ra];
      if (WRITE_FIRST && we && (wa == ra)) begin
        for (int l = 0; l < NL; l++) begin
          if (wmask[l]) rd_data_d[l*MW +: MW] = di[l*MW +: MW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_fire;
      if (rd_fire) rd_data_q <= rd_data_d;
    end
  end

  if (DOUT_REG != 0) begin : g_oreg
    logic [DW-1:0] dout_q;
    logic          dout_vld_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q     <= '0;
        dout_vld_q <= 1'b0;
      end else begin
        dout_vld_q <= rd_vld_q;
        if (rd_vld_q) dout_q <= rd_data_q;
      end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
  end else begin : g_noreg
    assign dout     = rd_data_q;
    assign dout_vld = rd_vld_q;
  end

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// Bench for nv_ram_rws_param: two configurations share one stimulus stream and
// are compared every cycle against a behavioural memory/latency model.
module tb_nv_ram_rws_param;

  logic         clk = 1'b0;
  logic         rst;
  logic         re;
  logic         we;
  logic [4:0]   ra;
  logic [4:0]   wa;
  logic [31:0]  wmask;
  logic [255:0] di;
  logic [31:0]  pwr;

  logic [255:0] dout_a;
  logic         dout_vld_a;
  logic         init_done_a;
  logic [31:0]  dout_b;
  logic         dout_vld_b;
  logic         init_done_b;

  always #5 clk = ~clk;

  // A: 32x256 write-first, cleared, no output register.
  nv_ram_rws_param #(
    .DEPTH(32), .DW(256), .MW(8), .DOUT_REG(0), .COLL_MODE(1), .CLEAR_ON_RST(1)
  ) u_a (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_a), .dout_vld(dout_vld_a),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(pwr), .init_done(init_done_a)
  );

  // B: 20x32 read-first, not cleared, registered output.
  nv_ram_rws_param #(
    .DEPTH(20), .DW(32), .MW(8), .DOUT_REG(1), .COLL_MODE(0), .CLEAR_ON_RST(0)
  ) u_b (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_b), .dout_vld(dout_vld_b),
    .wa(wa), .we(we), .wmask(wmask[3:0]), .di(di[31:0]), .pwrbus_ram_pd(pwr),
    .init_done(init_done_b)
  );

  localparam int DEP [2] = '{32, 20};
  localparam int LAT [2] = '{1, 2};
  localparam int RDY [2] = '{33, 1};
  localparam int LN  [2] = '{32, 4};
  localparam bit WF  [2] = '{1'b1, 1'b0};
  localparam bit CLR [2] = '{1'b1, 1'b0};

  typedef struct {
    int           inst;
    int           due;
    logic [255:0] data;
  } rd_t;

  logic [255:0] mem_m [2][32];
  int           ed [2];
  logic [255:0] exp_dout [2];
  bit           exp_vld [2];
  rd_t          pend [$];
  int           cyc = 0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] merge(input logic [255:0] old, input logic [31:0] m,
                                         input logic [255:0] d, input int lanes);
    merge = old;
    for (int l = 0; l < lanes; l++) begin
      if (m[l]) merge[l*8 +: 8] = d[l*8 +: 8];
    end
  endfunction

  function automatic logic [255:0] rnd256();
    for (int k = 0; k < 8; k++) rnd256[k*32 +: 32] = $urandom();
  endfunction

  // Applies the rules of one rising edge to the model, using the driven inputs.
  task automatic model_edge();
    rd_t          nq [$];
    logic [255:0] rdv;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      exp_vld[i] = 1'b0;
      if (rst) begin
        ed[i]       = 0;
        exp_dout[i] = '0;
      end else begin
        if (ed[i] >= RDY[i]) begin
          if (re) begin
            rdv = '0;
            if (int'(ra) < DEP[i]) begin
              rdv = mem_m[i][ra];
              if (we && (wa == ra) && WF[i]) rdv = merge(rdv, wmask, di, LN[i]);
            end
            pend.push_back('{i, cyc + LAT[i] - 1, rdv});
          end
          if (we && (int'(wa) < DEP[i])) mem_m[i][wa] = merge(mem_m[i][wa], wmask, di, LN[i]);
        end else if (CLR[i] && (ed[i] + 1 == DEP[i])) begin
          for (int a = 0; a < 32; a++) mem_m[i][a] = '0;
        end
        if (ed[i] < 1000) ed[i]++;
      end
    end
    if (rst) pend.delete();
    foreach (pend[k]) begin
      if (pend[k].due == cyc) begin
        exp_vld[pend[k].inst]  = 1'b1;
        exp_dout[pend[k].inst] = pend[k].data;
      end else begin
        nq.push_back(pend[k]);
      end
    end
    pend = nq;
  endtask

  task automatic step(input bit r_rst, input bit r_re, input logic [4:0] r_ra, input bit r_we,
                      input logic [4:0] r_wa, input logic [31:0] r_m, input logic [255:0] r_d);
    rst   = r_rst;
    re    = r_re;
    ra    = r_ra;
    we    = r_we;
    wa    = r_wa;
    wmask = r_m;
    di    = r_d;
    @(posedge clk);
    model_edge();
    #1;
    check("a_dout", dout_a, exp_dout[0]);
    check("a_vld", {255'd0, dout_vld_a}, {255'd0, exp_vld[0]});
    check("a_init", {255'd0, init_done_a}, {255'd0, (ed[0] >= RDY[0])});
    check("b_dout", {224'd0, dout_b}, {224'd0, exp_dout[1][31:0]});
    check("b_vld", {255'd0, dout_vld_b}, {255'd0, exp_vld[1]});
    check("b_init", {255'd0, init_done_b}, {255'd0, (ed[1] >= RDY[1])});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, '0);
  endtask

  task automatic rd(input int a);
    step(1'b0, 1'b1, 5'(a), 1'b0, 5'd0, 32'd0, '0);
  endtask

  task automatic wr(input int a, input logic [31:0] m, input logic [255:0] d);
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'(a), m, d);
  endtask

  // Runs with rst low until A reports init_done (bounded); optionally pokes writes at addr 0.
  task automatic run_clear(input bit poke, output int n);
    n = 0;
    do begin
      if (poke) step(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, '1, '1);
      else idle();
      n++;
    end while (!init_done_a && (n < 100));
  endtask

  initial begin
    int n;
    int cnt_a;
    int cnt_b;
    int r;
    int w;

    rst   = 1'b1;
    re    = 1'b0;
    we    = 1'b0;
    ra    = '0;
    wa    = '0;
    wmask = '0;
    di    = '0;
    pwr   = $urandom();
    for (int i = 0; i < 2; i++) begin
      ed[i]       = 0;
      exp_dout[i] = '0;
      exp_vld[i]  = 1'b0;
      for (int a = 0; a < 32; a++) mem_m[i][a] = '0;
    end

    step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, '0);
    step(1'b1, 1'b1, 5'd3, 1'b1, 5'd3, '1, '1);
    check("rst_dout_a", dout_a, '0);
    check("rst_init_a", {255'd0, init_done_a}, '0);

    run_clear(1'b0, n);
    check("init_edges_first", n, 33);

    // Fill both arrays with garbage, then reset and poke addr 0 during the clear walk.
    for (int a = 0; a < 32; a++) wr(a, '1, rnd256());
    step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, '0);
    run_clear(1'b1, n);
    check("init_edges_reset", n, 33);
    for (int a = 0; a < 32; a++) begin
      rd(a);
      check("cleared_a", dout_a, '0);
    end

    // Masked write: only the low four lanes are zeroed.
    wr(5, '1, '1);
    wr(5, 32'h0000_000F, '0);
    rd(5);
    idle();
    check("mask_a", dout_a, {{224{1'b1}}, 32'h0});
    check("mask_b", {224'd0, dout_b}, '0);

    // Collision on addr 7: A is write-first, B is read-first.
    wr(7, '1, {64{4'hA}});
    step(1'b0, 1'b1, 5'd7, 1'b1, 5'd7, '1, {64{4'h5}});
    check("coll_wf_a", dout_a, {64{4'h5}});
    idle();
    check("coll_rf_b", {224'd0, dout_b}, {224'd0, 32'hAAAA_AAAA});
    rd(7);
    idle();
    check("coll_after_a", dout_a, {64{4'h5}});
    check("coll_after_b", {224'd0, dout_b}, {224'd0, 32'h5555_5555});

    // Out-of-range for B (DEPTH 20), in range for A.
    wr(25, '1, 256'h1234);
    rd(25);
    idle();
    idle();
    check("oor_b", {224'd0, dout_b}, '0);
    check("addr25_a", dout_a, 256'h1234);
    rd(5);
    idle();
    check("alias5_b", {224'd0, dout_b}, '0);

    // Reset while the walk is at address 10, then a full walk from 0.
    step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, '0);
    for (int k = 0; k < 10; k++) idle();
    step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, '0);
    run_clear(1'b0, n);
    check("init_edges_midclear", n, 33);

    // 64 back-to-back reads with concurrent writes to other addresses.
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 66; k++) begin
      if (k < 64) begin
        r = int'($urandom_range(0, 31));
        w = (r + 1 + int'($urandom_range(0, 30))) % 32;
        step(1'b0, 1'b1, 5'(r), 1'($urandom_range(0, 1)), 5'(w), $urandom(), rnd256());
      end else begin
        idle();
      end
      cnt_a += int'(dout_vld_a);
      cnt_b += int'(dout_vld_b);
    end
    check("stream_vld_a", cnt_a, 64);
    check("stream_vld_b", cnt_b, 64);

    // Random mix, including frequent same-address collisions.
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 31));
      w = ($urandom_range(0, 3) == 0) ? r : int'($urandom_range(0, 31));
      step(1'b0, 1'($urandom_range(0, 1)), 5'(r), 1'($urandom_range(0, 1)), 5'(w),
           $urandom(), rnd256());
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
